// File: rtl/count_connected_feeder_pkg.sv
// rtl/count_connected_feeder_pkg.sv - shared widths and helpers for the connected-count feeder
`ifndef COUNT_CONNECTED_DEFS
`define COUNT_CONNECTED_DEFS
`define CC_GRAPH_WIDTH 128
`define CC_COUNT_WIDTH 6
`endif

package count_connected_feeder_pkg;
   localparam int GRAPH_W  = `CC_GRAPH_WIDTH;
   localparam int COUNT_W  = `CC_COUNT_WIDTH;
   localparam int BUBBLE_W = 32;

   function automatic logic [BUBBLE_W-1:0] sat_inc(input logic [BUBBLE_W-1:0] v);
      return (&v) ? v : v + BUBBLE_W'(1);
   endfunction
endpackage

// File: rtl/count_connected_feeder_fifo.sv
// rtl/count_connected_feeder_fifo.sv - show-ahead synchronous job FIFO with occupancy
module count_connected_feeder_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   occupancy_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign full_o      = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign do_push     = push_i & ~full_o;
   assign do_pop      = pop_i & ~empty_o;
   assign rdata_o     = mem_q[rd_ptr_q];
   assign occupancy_o = count_q;

   // Pointers are exactly DEPTH_LOG2 bits wide so they wrap without explicit logic.
   always_comb begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_push);
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_pop);
      count_d  = count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end
endmodule

// File: rtl/count_connected_feeder.sv
// rtl/count_connected_feeder.sv - job FIFO, fixed-latency start pipe and stretched core reset
module count_connected_feeder
   import count_connected_feeder_pkg::*;
#(
   parameter int EXTRA_DATA_WIDTH = 10,
   parameter int DATA_IN_LATENCY  = 4,
   parameter int FIFO_DEPTH_LOG2  = 4,
   parameter int CORE_RST_CYCLES  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        writeValid,
   output logic                        writeReady,
   input  logic [GRAPH_W-1:0]          writeGraph,
   input  logic [COUNT_W-1:0]          writeConnectCount,
   input  logic [EXTRA_DATA_WIDTH-1:0] writeExtraData,
   output logic                        coreRst,
   input  logic                        coreRequest,
   output logic                        coreStart,
   output logic [GRAPH_W-1:0]          coreGraph,
   output logic [COUNT_W-1:0]          coreConnectCount,
   output logic [EXTRA_DATA_WIDTH-1:0] coreExtraData,
   output logic [FIFO_DEPTH_LOG2:0]    occupancy,
   output logic [BUBBLE_W-1:0]         bubbleCount
);
   localparam int JOB_W     = GRAPH_W + COUNT_W + EXTRA_DATA_WIDTH;
   localparam int RST_CNT_W = $clog2(CORE_RST_CYCLES + 1);

   logic [RST_CNT_W-1:0]       rst_cnt_q, rst_cnt_d;
   logic [BUBBLE_W-1:0]        bubble_q, bubble_d;
   logic [DATA_IN_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [JOB_W-1:0]           pipe_data_q [DATA_IN_LATENCY];
   logic [JOB_W-1:0]           pipe_data_d [DATA_IN_LATENCY];
   logic [JOB_W-1:0]           fifo_rdata;
   logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic                       core_open, bubble;

   assign coreRst    = (rst_cnt_q != '0);
   assign writeReady = rst & ~fifo_full;
   assign fifo_push  = writeValid & writeReady;
   assign core_open  = coreRequest & ~coreRst;
   assign fifo_pop   = core_open & ~fifo_empty;
   assign bubble     = core_open & fifo_empty;

   count_connected_feeder_fifo #(
      .WIDTH      (JOB_W),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .pop_i       (fifo_pop),
      .wdata_i     ({writeGraph, writeConnectCount, writeExtraData}),
      .rdata_o     (fifo_rdata),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .occupancy_o (occupancy)
   );

   // Bubbles enter the pipe as all-zero data so idle outputs never show stale jobs.
   always_comb begin
      rst_cnt_d      = coreRst ? rst_cnt_q - RST_CNT_W'(1) : rst_cnt_q;
      bubble_d       = bubble ? sat_inc(bubble_q) : bubble_q;
      pipe_vld_d[0]  = fifo_pop;
      pipe_data_d[0] = fifo_pop ? fifo_rdata : '0;
      for (int i = 1; i < DATA_IN_LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_data_d[i] = pipe_data_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rst_cnt_q  <= RST_CNT_W'(CORE_RST_CYCLES);
         bubble_q   <= '0;
         pipe_vld_q <= '0;
         for (int i = 0; i < DATA_IN_LATENCY; i++) begin
            pipe_data_q[i] <= '0;
         end
      end else begin
         rst_cnt_q  <= rst_cnt_d;
         bubble_q   <= bubble_d;
         pipe_vld_q <= pipe_vld_d;
         for (int i = 0; i < DATA_IN_LATENCY; i++) begin
            pipe_data_q[i] <= pipe_data_d[i];
         end
      end
   end

   assign coreStart   = pipe_vld_q[DATA_IN_LATENCY-1];
   assign {coreGraph, coreConnectCount, coreExtraData} = pipe_data_q[DATA_IN_LATENCY-1];
   assign bubbleCount = bubble_q;
endmodule

// File: tb/tb_count_connected_feeder.sv
// tb/tb_count_connected_feeder.sv - self-checking bench for count_connected_feeder
module tb_count_connected_feeder;
   localparam int XW    = 10;
   localparam int LAT   = 4;
   localparam int DL2   = 4;
   localparam int DEPTH = 16;
   localparam int RSTC  = 32;

   logic          clk = 1'b0;
   logic          rst, writeValid, writeReady, coreRst, coreRequest, coreStart;
   logic [127:0]  writeGraph, coreGraph;
   logic [5:0]    writeConnectCount, coreConnectCount;
   logic [XW-1:0] writeExtraData, coreExtraData;
   logic [DL2:0]  occupancy;
   logic [31:0]   bubbleCount;

   always #5 clk = ~clk;

   count_connected_feeder #(
      .EXTRA_DATA_WIDTH (XW),
      .DATA_IN_LATENCY  (LAT),
      .FIFO_DEPTH_LOG2  (DL2),
      .CORE_RST_CYCLES  (RSTC)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .writeValid        (writeValid),
      .writeReady        (writeReady),
      .writeGraph        (writeGraph),
      .writeConnectCount (writeConnectCount),
      .writeExtraData    (writeExtraData),
      .coreRst           (coreRst),
      .coreRequest       (coreRequest),
      .coreStart         (coreStart),
      .coreGraph         (coreGraph),
      .coreConnectCount  (coreConnectCount),
      .coreExtraData     (coreExtraData),
      .occupancy         (occupancy),
      .bubbleCount       (bubbleCount)
   );

   typedef struct packed {
      logic [127:0]  g;
      logic [5:0]    c;
      logic [XW-1:0] x;
   } job_t;

   // Reference model: a job queue, a map from clock edge to the job due after it,
   // remaining core-reset cycles, and the bubble tally.
   job_t        fifo_m[$];
   job_t        due_m[int];
   int          cyc = 0;
   int          rst_left = 0;
   logic [31:0] bub_m = '0;
   logic        exp_start;
   job_t        exp_job;
   int          vectors = 0;
   int          errors = 0;

   task automatic tick();
      job_t j;
      logic ready;
      @(posedge clk);
      cyc++;
      if (!rst) begin
         fifo_m.delete();
         due_m.delete();
         rst_left = RSTC;
         bub_m    = '0;
      end else begin
         ready = (fifo_m.size() < DEPTH);
         if (coreRequest && rst_left == 0) begin
            if (fifo_m.size() > 0) begin
               j = fifo_m.pop_front();
               due_m[cyc + LAT - 1] = j;
            end else if (bub_m != 32'hFFFF_FFFF) begin
               bub_m = bub_m + 1;
            end
         end
         if (writeValid && ready)
            fifo_m.push_back(job_t'({writeGraph, writeConnectCount, writeExtraData}));
         if (rst_left > 0) rst_left--;
      end
      exp_start = due_m.exists(cyc);
      exp_job   = exp_start ? due_m[cyc] : '0;
      if (exp_start) due_m.delete(cyc);
      #1;
   endtask

   task automatic idle();
      writeValid        = 1'b0;
      coreRequest       = 1'b0;
      writeGraph        = '0;
      writeConnectCount = '0;
      writeExtraData    = '0;
   endtask

   task automatic rand_job();
      writeGraph        = {$urandom, $urandom, $urandom, $urandom};
      writeConnectCount = 6'($urandom);
      writeExtraData    = XW'($urandom);
   endtask

   task automatic test_reset();
      int n = 0;
      rst = 1'b0;
      idle();
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (coreRst !== 1'b1 || coreStart !== 1'b0 || occupancy !== '0 || bubbleCount !== '0 ||
             writeReady !== 1'b0 || coreGraph !== '0 || coreConnectCount !== '0 || coreExtraData !== '0) begin
            errors++;
            $display("FAIL reset_state: rst=%b start=%b occ=%0d bub=%0d wr=%b, required rst=1 others 0",
                     coreRst, coreStart, occupancy, bubbleCount, writeReady);
         end
      end
      rst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (coreRst === 1'b1) n++;
         tick();
         vectors++;
         if (coreRst !== (rst_left != 0) || coreStart !== 1'b0 || coreGraph !== '0) begin
            errors++;
            $display("FAIL reset_release: cycle %0d coreRst=%b start=%b, required coreRst=%b start=0",
                     i, coreRst, coreStart, rst_left != 0);
         end
      end
      vectors++;
      if (n != RSTC) begin
         errors++;
         $display("FAIL stretch_len: coreRst high %0d cycles, required %0d", n, RSTC);
      end
   endtask

   task automatic test_single();
      writeValid = 1'b1;
      writeGraph = 128'h1;
      writeConnectCount = 6'd3;
      writeExtraData = 10'h2A;
      vectors++;
      if (writeReady !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: writeReady=%b, required 1", writeReady);
      end
      tick();
      idle();
      vectors++;
      if (occupancy !== 5'd1) begin
         errors++;
         $display("FAIL single_occ_push: occupancy=%0d, required 1", occupancy);
      end
      coreRequest = 1'b1;
      tick();
      coreRequest = 1'b0;
      vectors++;
      if (occupancy !== 5'd0 || coreStart !== 1'b0) begin
         errors++;
         $display("FAIL single_pop: occupancy=%0d start=%b, required 0 0", occupancy, coreStart);
      end
      for (int k = 2; k <= 6; k++) begin
         tick();
         vectors++;
         if (coreStart !== (k == LAT)) begin
            errors++;
            $display("FAIL single_start: t+%0d coreStart=%b, required %b", k, coreStart, k == LAT);
         end
         if (k == LAT) begin
            vectors++;
            if (coreGraph !== 128'h1 || coreConnectCount !== 6'd3 || coreExtraData !== 10'h2A) begin
               errors++;
               $display("FAIL single_fields: graph=%h count=%0d tag=%h, required 1 3 02a",
                        coreGraph, coreConnectCount, coreExtraData);
            end
         end
      end
   endtask

   task automatic test_bubble();
      vectors++;
      if (bubbleCount !== 32'd0) begin
         errors++;
         $display("FAIL bubble_before: bubbleCount=%0d, required 0", bubbleCount);
      end
      coreRequest = 1'b1;
      tick();
      coreRequest = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         tick();
         vectors++;
         if (coreStart !== 1'b0 || coreGraph !== '0) begin
            errors++;
            $display("FAIL bubble_start: t+%0d coreStart=%b graph=%h, required 0", k, coreStart, coreGraph);
         end
      end
      vectors++;
      if (bubbleCount !== 32'd1) begin
         errors++;
         $display("FAIL bubble_count: bubbleCount=%0d, required 1", bubbleCount);
      end
   endtask

   task automatic test_full();
      writeValid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         rand_job();
         tick();
      end
      rand_job();
      vectors++;
      if (occupancy !== 5'd16 || writeReady !== 1'b0) begin
         errors++;
         $display("FAIL full_state: occupancy=%0d writeReady=%b, required 16 0", occupancy, writeReady);
      end
      tick();
      tick();
      vectors++;
      if (occupancy !== 5'd16) begin
         errors++;
         $display("FAIL full_hold: occupancy=%0d, required 16", occupancy);
      end
      coreRequest = 1'b1;
      tick();
      coreRequest = 1'b0;
      vectors++;
      if (occupancy !== 5'd15 || writeReady !== 1'b1) begin
         errors++;
         $display("FAIL full_poppush: occupancy=%0d writeReady=%b, required 15 1", occupancy, writeReady);
      end
      tick();
      writeValid = 1'b0;
      vectors++;
      if (occupancy !== 5'd16) begin
         errors++;
         $display("FAIL full_late_accept: occupancy=%0d, required 16", occupancy);
      end
      coreRequest = 1'b1;
      for (int i = 0; i < 26; i++) begin
         if (i == 20) coreRequest = 1'b0;
         tick();
         vectors++;
         if ({coreStart, coreGraph, coreConnectCount, coreExtraData} !== {exp_start, exp_job} ||
             occupancy !== 5'(fifo_m.size())) begin
            errors++;
            $display("FAIL drain: cycle %0d start=%b job=%h occ=%0d, required start=%b job=%h occ=%0d",
                     i, coreStart, {coreGraph, coreConnectCount, coreExtraData}, occupancy,
                     exp_start, exp_job, fifo_m.size());
         end
      end
   endtask

   task automatic test_back_to_back();
      job_t jobs [3];
      writeValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_job();
         jobs[i] = job_t'({writeGraph, writeConnectCount, writeExtraData});
         tick();
      end
      idle();
      tick();
      coreRequest = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         if (k == 4) coreRequest = 1'b0;
         tick();
         vectors++;
         if (k >= LAT && k < LAT + 3) begin
            if (coreStart !== 1'b1 || {coreGraph, coreConnectCount, coreExtraData} !== jobs[k-LAT]) begin
               errors++;
               $display("FAIL b2b_order: t+%0d start=%b job=%h, required 1 %h", k, coreStart,
                        {coreGraph, coreConnectCount, coreExtraData}, jobs[k-LAT]);
            end
         end else if (coreStart !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: t+%0d coreStart=%b, required 0", k, coreStart);
         end
      end
   endtask

   task automatic test_reset_midflight();
      writeValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_job();
         tick();
      end
      idle();
      coreRequest = 1'b1;
      tick();
      tick();
      coreRequest = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      vectors++;
      if (coreStart !== 1'b0 || occupancy !== '0 || bubbleCount !== '0 || coreRst !== 1'b1) begin
         errors++;
         $display("FAIL midflight_reset: start=%b occ=%0d bub=%0d coreRst=%b, required 0 0 0 1",
                  coreStart, occupancy, bubbleCount, coreRst);
      end
      coreRequest = 1'b1;
      writeValid  = 1'b1;
      rand_job();
      for (int i = 0; i < RSTC + 6; i++) begin
         tick();
         writeValid = 1'b0;
         if (i == RSTC - 1) coreRequest = 1'b0;
         vectors++;
         if (coreStart !== exp_start || coreRst !== (rst_left != 0) || bubbleCount !== bub_m ||
             occupancy !== 5'(fifo_m.size()) || (i < RSTC && (coreStart !== 1'b0 || occupancy !== 5'd1))) begin
            errors++;
            $display("FAIL midflight_stretch: cycle %0d start=%b coreRst=%b bub=%0d occ=%0d, required start=%b coreRst=%b bub=%0d occ=%0d",
                     i, coreStart, coreRst, bubbleCount, occupancy, exp_start, rst_left != 0, bub_m, fifo_m.size());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         rst         = ($urandom_range(0, 199) != 0);
         writeValid  = ($urandom_range(0, 1) == 1);
         coreRequest = ($urandom_range(0, 2) != 0);
         rand_job();
         tick();
         vectors++;
         if ({coreStart, coreGraph, coreConnectCount, coreExtraData} !== {exp_start, exp_job} ||
             occupancy !== 5'(fifo_m.size()) || bubbleCount !== bub_m || coreRst !== (rst_left != 0) ||
             writeReady !== (rst && fifo_m.size() < DEPTH)) begin
            errors++;
            $display("FAIL random: cycle %0d start=%b job=%h occ=%0d bub=%0d rst=%b wr=%b, required %b %h %0d %0d %b %b",
                     i, coreStart, {coreGraph, coreConnectCount, coreExtraData}, occupancy, bubbleCount,
                     coreRst, writeReady, exp_start, exp_job, fifo_m.size(), bub_m, rst_left != 0,
                     rst && fifo_m.size() < DEPTH);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_bubble();
      test_full();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
